// File: rtl/team_wb_pkg.sv
// Shared definitions for the team Wishbone register block: register offsets,
// CTRL bit positions, bus FSM states and byte-lane helpers.
package team_wb_pkg;

    localparam logic [5:0] CTRL_OFS      = 6'h00;
    localparam logic [5:0] GPIO_OUT_OFS  = 6'h04;
    localparam logic [5:0] GPIO_OE_OFS   = 6'h08;
    localparam logic [5:0] GPIO_IN_OFS   = 6'h0C;
    localparam logic [5:0] CYCLE_CNT_OFS = 6'h10;
    localparam logic [5:0] ID_OFS        = 6'h14;
    localparam logic [5:0] EDGE_STAT_OFS = 6'h18;
    localparam logic [5:0] IRQ_EN_OFS    = 6'h1C;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/team_sync_edge.sv
// Two-flop synchronizer for the GPIO pads plus a third stage used only to
// detect rising edges of the synchronized value.
module team_sync_edge #(
    parameter int NGPIO = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NGPIO-1:0] din,
    output logic [NGPIO-1:0] sync,
    output logic [NGPIO-1:0] rise
);

    logic [NGPIO-1:0] sync1_q, sync1_d;
    logic [NGPIO-1:0] sync2_q, sync2_d;
    logic [NGPIO-1:0] sync3_q, sync3_d;

    // shift chain next values
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // synchronizer and edge-history flops
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign sync = sync2_q;
    assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/team_wb_regs.sv
// Wishbone classic register file for a team wrapper: enable, GPIO control,
// synchronized GPIO inputs, cycle counter and rising-edge interrupt.
module team_wb_regs
    import team_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NGPIO     = 32,
    parameter logic [31:0] TEAM_ID   = 32'h0000_0009
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_oe,
    output logic             en,
    output logic             irq
);

    wb_state_e        state_q, state_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             en_q, en_d;
    logic [NGPIO-1:0] gpio_out_q, gpio_out_d;
    logic [NGPIO-1:0] gpio_oe_q, gpio_oe_d;
    logic [NGPIO-1:0] edge_q, edge_d;
    logic [NGPIO-1:0] irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [31:0]      cnt_q, cnt_d;

    logic             hit_s, req_s, wr_s, rd_s;
    logic [5:0]       ofs_s;
    logic [31:0]      bmask_s;
    logic [31:0]      wr_bits_s;
    logic [31:0]      gpio_out_wr_s, gpio_oe_wr_s, irq_en_wr_s;
    logic [31:0]      rdata_s;
    logic [NGPIO-1:0] w1c_s;
    logic             cnt_clr_s;
    logic [NGPIO-1:0] sync_s, rise_s;
    logic             unused_s;

    team_sync_edge #(
        .NGPIO (NGPIO)
    ) u_sync_edge (
        .clk  (clk),
        .nrst (nrst),
        .din  (gpio_in),
        .sync (sync_s),
        .rise (rise_s)
    );

    // Byte address bits [1:0] carry no information for word registers.
    assign unused_s = ^wbs_adr_i[1:0];

    assign hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign req_s     = hit_s & (state_q == ST_IDLE);
    assign wr_s      = req_s & wbs_we_i;
    assign rd_s      = req_s & ~wbs_we_i;
    assign ofs_s     = {wbs_adr_i[5:2], 2'b00};
    assign bmask_s   = sel_to_mask(wbs_sel_i);
    assign wr_bits_s = wbs_dat_i & bmask_s;

    assign gpio_out_wr_s = merge_bytes(32'(gpio_out_q), wbs_dat_i, bmask_s);
    assign gpio_oe_wr_s  = merge_bytes(32'(gpio_oe_q), wbs_dat_i, bmask_s);
    assign irq_en_wr_s   = merge_bytes(32'(irq_en_q), wbs_dat_i, bmask_s);

    // bus FSM: accept in IDLE, single ack cycle, never sample while acking
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack_d = (state_d == ST_ACK);
    end

    // read mux; unmapped offsets inside the window read as zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (ofs_s)
            CTRL_OFS:      rdata_s = {31'h0000_0000, en_q};
            GPIO_OUT_OFS:  rdata_s = 32'(gpio_out_q);
            GPIO_OE_OFS:   rdata_s = 32'(gpio_oe_q);
            GPIO_IN_OFS:   rdata_s = 32'(sync_s);
            CYCLE_CNT_OFS: rdata_s = cnt_q;
            ID_OFS:        rdata_s = TEAM_ID;
            EDGE_STAT_OFS: rdata_s = 32'(edge_q);
            IRQ_EN_OFS:    rdata_s = 32'(irq_en_q);
            default:       rdata_s = 32'h0000_0000;
        endcase
        if (rd_s) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0000_0000;
        end
    end

    // register write decode with per-byte lane enables
    always_comb begin
        en_d       = en_q;
        cnt_clr_s  = 1'b0;
        gpio_out_d = gpio_out_q;
        gpio_oe_d  = gpio_oe_q;
        irq_en_d   = irq_en_q;
        w1c_s      = '0;
        if (wr_s) begin
            case (ofs_s)
                CTRL_OFS: begin
                    if (wbs_sel_i[0]) begin
                        en_d      = wbs_dat_i[CTRL_EN_BIT];
                        cnt_clr_s = wbs_dat_i[CTRL_CLR_BIT];
                    end else begin
                        en_d      = en_q;
                        cnt_clr_s = 1'b0;
                    end
                end
                GPIO_OUT_OFS:  gpio_out_d = gpio_out_wr_s[NGPIO-1:0];
                GPIO_OE_OFS:   gpio_oe_d  = gpio_oe_wr_s[NGPIO-1:0];
                EDGE_STAT_OFS: w1c_s      = wr_bits_s[NGPIO-1:0];
                IRQ_EN_OFS:    irq_en_d   = irq_en_wr_s[NGPIO-1:0];
                default:       w1c_s      = '0;
            endcase
        end else begin
            w1c_s = '0;
        end
    end

    // status, interrupt and counter; a new edge beats a same-cycle clear
    always_comb begin
        edge_d = (edge_q & ~w1c_s) | rise_s;
        irq_d  = |(edge_q & irq_en_q);
        if (cnt_clr_s) begin
            cnt_d = 32'h0000_0000;
        end else if (en_q) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0000_0000;
            en_q       <= 1'b0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            edge_q     <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            cnt_q      <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            en_q       <= en_d;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
            edge_q     <= edge_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = gpio_out_q;
    assign gpio_oe   = gpio_oe_q;
    assign en        = en_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_team_wb_regs.sv
// Directed self-checking bench for team_wb_regs: bus protocol, register
// behaviour, counter, GPIO edge interrupt and reset handling.
module tb_team_wb_regs;

    localparam int NGPIO = 32;
    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_GOUT = 32'h3000_0004;
    localparam logic [31:0] A_GOE  = 32'h3000_0008;
    localparam logic [31:0] A_GIN  = 32'h3000_000C;
    localparam logic [31:0] A_CNT  = 32'h3000_0010;
    localparam logic [31:0] A_ID   = 32'h3000_0014;
    localparam logic [31:0] A_EDGE = 32'h3000_0018;
    localparam logic [31:0] A_IEN  = 32'h3000_001C;

    logic             clk = 1'b0;
    logic             nrst;
    logic             wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]       wbs_sel_i;
    logic [31:0]      wbs_adr_i, wbs_dat_i;
    logic             wbs_ack_o;
    logic [31:0]      wbs_dat_o;
    logic [NGPIO-1:0] gpio_in, gpio_out, gpio_oe;
    logic             en, irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    team_wb_regs #(
        .BASE_ADDR (32'h3000_0000),
        .NGPIO     (NGPIO),
        .TEAM_ID   (32'h0000_0009)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .en        (en),
        .irq       (irq)
    );

    // One bus access; lat = cycles from strobe to ack, -1 if no ack in 20.
    // After an ack it waits one more edge so the next access starts in IDLE.
    task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        lat = -1; rd = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                lat = i; rd = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int lat;
        bus_cycle(1'b1, a, d, s, rd, lat);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
        int lat;
        bus_cycle(1'b0, a, 32'h0, 4'hF, v, lat);
    endtask

    task automatic test_reset;
        logic [31:0] v; int lat;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({wbs_ack_o, wbs_dat_o, gpio_out, gpio_oe, en, irq} !== '0) begin
            $display("FAIL reset_outputs: got ack=%b dat=%h out=%h oe=%h en=%b irq=%b, want all 0",
                     wbs_ack_o, wbs_dat_o, gpio_out, gpio_oe, en, irq);
            n_fail++;
        end
        @(negedge clk); nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({wbs_ack_o, wbs_dat_o, gpio_out, gpio_oe, en, irq} !== '0) begin
            $display("FAIL post_reset_outputs: some output nonzero, want all 0");
            n_fail++;
        end
        bus_cycle(1'b0, A_ID, 32'h0, 4'hF, v, lat);
        n_checks++;
        if (lat !== 1) begin
            $display("FAIL id_latency: got %0d cycles, want 1", lat);
            n_fail++;
        end
        n_checks++;
        if (v !== 32'h0000_0009) begin
            $display("FAIL id_data: got %h, want 00000009", v);
            n_fail++;
        end
        n_checks++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            $display("FAIL ack_single_pulse: ack=%b dat=%h one cycle later, want 0/0", wbs_ack_o, wbs_dat_o);
            n_fail++;
        end
    endtask

    task automatic test_counter;
        logic [31:0] v, v2;
        wr(A_CTRL, 32'h1, 4'hF);
        n_checks++;
        if (en !== 1'b1) begin
            $display("FAIL en_set: got %b, want 1", en);
            n_fail++;
        end
        repeat (100) @(posedge clk);
        rd_reg(A_CNT, v);
        n_checks++;
        if (v < 32'd97 || v > 32'd103) begin
            $display("FAIL cnt_run: got %0d, want 97..103", v);
            n_fail++;
        end
        wr(A_CTRL, 32'h2, 4'hF);
        rd_reg(A_CNT, v);
        n_checks++;
        if (v !== 32'd0) begin
            $display("FAIL cnt_clear: got %0d, want 0", v);
            n_fail++;
        end
        wr(A_CTRL, 32'h3, 4'hF);
        rd_reg(A_CTRL, v);
        n_checks++;
        if (v !== 32'h1) begin
            $display("FAIL ctrl_readback: got %h, want 00000001 (CNT_CLR reads 0)", v);
            n_fail++;
        end
        rd_reg(A_CNT, v);
        n_checks++;
        if (v !== 32'd3) begin
            $display("FAIL cnt_clr_en_start: got %0d, want 3", v);
            n_fail++;
        end
        wr(A_CTRL, 32'h0, 4'hF);
        rd_reg(A_CNT, v);
        rd_reg(A_CNT, v2);
        n_checks++;
        if (v2 !== v || en !== 1'b0) begin
            $display("FAIL cnt_hold: reads %0d then %0d en=%b, want equal and en 0", v, v2, en);
            n_fail++;
        end
    endtask

    task automatic test_gpio_regs;
        logic [31:0] v;
        wr(A_GOE, 32'hFFFF_0000, 4'b1100);
        rd_reg(A_GOE, v);
        n_checks++;
        if (v !== 32'hFFFF_0000 || gpio_oe !== 32'hFFFF_0000) begin
            $display("FAIL oe_upper: read %h port %h, want FFFF0000", v, gpio_oe);
            n_fail++;
        end
        wr(A_GOE, 32'h0000_00FF, 4'b0001);
        rd_reg(A_GOE, v);
        n_checks++;
        if (v !== 32'hFFFF_00FF) begin
            $display("FAIL oe_lane0: got %h, want FFFF00FF", v);
            n_fail++;
        end
        wr(A_GOUT, 32'hA5A5_5A5A, 4'hF);
        wr(A_GOUT, 32'h0000_0000, 4'h0);
        rd_reg(A_GOUT, v);
        n_checks++;
        if (v !== 32'hA5A5_5A5A || gpio_out !== 32'hA5A5_5A5A) begin
            $display("FAIL gpio_out: read %h port %h, want A5A55A5A", v, gpio_out);
            n_fail++;
        end
    endtask

    task automatic test_edge_irq;
        logic [31:0] v; int lat;
        wr(A_IEN, 32'h8, 4'hF);
        @(negedge clk); gpio_in = 32'h8;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (irq && lat < 0) lat = i;
        end
        n_checks++;
        if (lat !== 4) begin
            $display("FAIL irq_latency: got %0d cycles, want 4", lat);
            n_fail++;
        end
        rd_reg(A_EDGE, v);
        n_checks++;
        if (v !== 32'h8) begin
            $display("FAIL edge_stat_set: got %h, want 00000008", v);
            n_fail++;
        end
        rd_reg(A_GIN, v);
        n_checks++;
        if (v !== 32'h8) begin
            $display("FAIL gpio_in_read: got %h, want 00000008", v);
            n_fail++;
        end
        wr(A_EDGE, 32'h8, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_clear: got %b, want 0", irq);
            n_fail++;
        end
        gpio_in = 32'h0;
        repeat (4) @(posedge clk);
        // rise appears at the third edge after the pad change; W1C lands there
        @(negedge clk); gpio_in = 32'h8;
        @(posedge clk);
        @(posedge clk);
        wr(A_EDGE, 32'h8, 4'hF);
        rd_reg(A_EDGE, v);
        n_checks++;
        if (v !== 32'h8 || irq !== 1'b1) begin
            $display("FAIL set_beats_clear: stat %h irq %b, want 00000008/1", v, irq);
            n_fail++;
        end
        wr(A_EDGE, 32'h8, 4'b1110);
        rd_reg(A_EDGE, v);
        n_checks++;
        if (v !== 32'h8) begin
            $display("FAIL w1c_unselected: got %h, want 00000008", v);
            n_fail++;
        end
        wr(A_EDGE, 32'h8, 4'b0001);
        rd_reg(A_EDGE, v);
        n_checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            $display("FAIL w1c_selected: stat %h irq %b, want 0/0", v, irq);
            n_fail++;
        end
    endtask

    task automatic test_address_window;
        logic [31:0] v; int lat;
        bus_cycle(1'b0, 32'h3000_0040, 32'h0, 4'hF, v, lat);
        n_checks++;
        if (lat !== -1) begin
            $display("FAIL miss_no_ack: acked after %0d cycles, want no ack", lat);
            n_fail++;
        end
        bus_cycle(1'b0, 32'h3000_0024, 32'h0, 4'hF, v, lat);
        n_checks++;
        if (lat !== 1 || v !== 32'h0) begin
            $display("FAIL unmapped_read: lat %0d data %h, want 1/00000000", lat, v);
            n_fail++;
        end
        wr(32'h3000_0020, 32'hFFFF_FFFF, 4'hF);
        rd_reg(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0 || en !== 1'b0) begin
            $display("FAIL unmapped_write: CTRL %h en %b, want 0/0", v, en);
            n_fail++;
        end
        rd_reg(32'h3000_0017, v);
        n_checks++;
        if (v !== 32'h0000_0009) begin
            $display("FAIL low_addr_bits: got %h, want 00000009", v);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        int acks; logic bad;
        acks = 0; bad = 1'b0;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = A_ID; wbs_sel_i = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) acks++;
            if (wbs_ack_o !== logic'(i % 2)) bad = 1'b1;
            if (wbs_ack_o && wbs_dat_o !== 32'h9) bad = 1'b1;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (acks !== 3 || bad) begin
            $display("FAIL held_strobe: %0d acks pattern_bad=%b, want 3 on alternate cycles", acks, bad);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = A_CTRL; wbs_dat_i = 32'h1; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (wbs_ack_o !== 1'b1 || en !== 1'b1) begin
            $display("FAIL mid_in_ack: ack %b en %b, want 1/1", wbs_ack_o, en);
            n_fail++;
        end
        nrst = 1'b0;
        #1;
        n_checks++;
        if (wbs_ack_o !== 1'b0 || en !== 1'b0) begin
            $display("FAIL mid_reset_async: ack %b en %b, want 0/0", wbs_ack_o, en);
            n_fail++;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        rd_reg(A_CTRL, v);
        n_checks++;
        if (v !== 32'h0) begin
            $display("FAIL ctrl_after_reset: got %h, want 00000000", v);
            n_fail++;
        end
    endtask

    initial begin
        nrst = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        gpio_in = '0;
        test_reset();
        test_counter();
        test_gpio_regs();
        test_edge_irq();
        test_address_window();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
